// File: rtl/fifo_read_checker.sv
// Read-side checker for a FIFO carrying packed counter pairs {n, n+1}.
// Locks onto the sequence, counts words and mismatches, and flags read stalls.
module fifo_read_checker #(
    parameter int DATA_WIDTH    = 32,
    parameter int HALF_WIDTH    = 16,
    parameter int TIMEOUT       = 1024,
    parameter int ERR_CNT_WIDTH = 16
) (
    input  logic                     rd_clk_i,
    input  logic                     sys_rst_n,
    input  logic                     prog_full_i,
    input  logic                     empty_i,
    input  logic                     stop_fifo_rd,
    input  logic [DATA_WIDTH-1:0]    rdata,
    input  logic                     rd_valid_i,
    output logic                     rd_en_o,
    output logic                     locked_o,
    output logic                     err_o,
    output logic                     stall_o,
    output logic [ERR_CNT_WIDTH-1:0] err_cnt_o,
    output logic [31:0]              word_cnt_o,
    output logic [DATA_WIDTH-1:0]    first_err_data_o,
    output logic [DATA_WIDTH-1:0]    first_err_exp_o,
    output logic [1:0]               dbg_state
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]         T_MAX  = TW'(TIMEOUT);
    localparam logic [TW-1:0]         T_LAST = TW'(TIMEOUT - 1);
    localparam logic [HALF_WIDTH-1:0] ONE    = HALF_WIDTH'(1);
    localparam logic [HALF_WIDTH-1:0] TWO    = HALF_WIDTH'(2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [HALF_WIDTH-1:0] hi, lo, exp_n;
    logic [TW-1:0]         tmo_cnt;
    logic                  pair_ok, match, lock_now, word_ok, word_bad;

    // empty_i is deliberately unused: read enable is not gated by it
    logic unused_empty;
    assign unused_empty = empty_i;

    assign hi        = rdata[DATA_WIDTH-1:HALF_WIDTH];
    assign lo        = rdata[HALF_WIDTH-1:0];
    assign pair_ok   = (lo == hi + ONE);
    assign match     = (hi == exp_n) && (lo == exp_n + ONE);
    assign dbg_state = state;

    always_comb begin
        state_nxt = state;
        lock_now  = 1'b0;
        word_ok   = 1'b0;
        word_bad  = 1'b0;
        case (state)
            IDLE: if (prog_full_i) state_nxt = SYNC;
            SYNC: if (rd_valid_i && pair_ok) begin
                state_nxt = RUN;
                lock_now  = 1'b1;
            end
            RUN: if (rd_valid_i) begin
                if (match) begin
                    word_ok = 1'b1;
                end else begin
                    word_bad  = 1'b1;
                    state_nxt = SYNC;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge rd_clk_i or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state            <= IDLE;
            rd_en_o          <= 1'b0;
            locked_o         <= 1'b0;
            exp_n            <= '0;
            word_cnt_o       <= '0;
            err_o            <= 1'b0;
            err_cnt_o        <= '0;
            first_err_data_o <= '0;
            first_err_exp_o  <= '0;
        end else begin
            state    <= state_nxt;
            rd_en_o  <= (state != IDLE) && stop_fifo_rd;
            locked_o <= (state_nxt == RUN);
            if (lock_now)
                exp_n <= lo + ONE;
            else if (word_ok)
                exp_n <= exp_n + TWO;
            if (lock_now || word_ok || word_bad)
                word_cnt_o <= word_cnt_o + 32'd1;
            if (word_bad) begin
                err_o <= 1'b1;
                if (err_cnt_o != '1)
                    err_cnt_o <= err_cnt_o + ERR_CNT_WIDTH'(1);
                // err_o still low means this is the first mismatch since reset
                if (!err_o) begin
                    first_err_data_o <= rdata;
                    first_err_exp_o  <= {exp_n, exp_n + ONE};
                end
            end
        end
    end

    always_ff @(posedge rd_clk_i or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tmo_cnt <= '0;
            stall_o <= 1'b0;
        end else if (rd_valid_i || !rd_en_o) begin
            tmo_cnt <= '0;
        end else if (tmo_cnt != T_MAX) begin
            tmo_cnt <= tmo_cnt + TW'(1);
            if (tmo_cnt == T_LAST)
                stall_o <= 1'b1;
        end
    end

endmodule
